ahbl_wrr_grant: RTL and testbench

Weighted round-robin grant scheduler for one AHB-Lite slave port shared by N_PORTS masters. Sits inside the per-slave arbiter of the crossbar. Decides which master owns the address phase and tracks which master owns the data phase. Honours HMASTLOCK and per-master weights; it carries no bus payload, only grant state.

---
 rtl/ahbl_pkg.sv | 31 +++
 rtl/ahbl_wrr_grant_if.sv | 31 +++
 rtl/onehot_rr_pick.sv | 31 +++
 rtl/ahbl_wrr_grant.sv | 105 ++++++++++
 tb/tb_ahbl_wrr_grant.sv | 139 +++++++++++++
 5 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the crossbar arbiters: transfer encodings
// and a constant-foldable log2 helper for sizing index fields.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Ceiling log2, never below 1 so a 1-bit index field always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ahbl_wrr_grant_if.sv
// Grant-state bundle between a per-slave arbiter parent (master side) and the
// weighted round-robin grant scheduler (slave side).
interface ahbl_wrr_grant_if
  import ahbl_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int W_WEIGHT = 4,
  parameter int W_IDX    = clog2(N_PORTS)
);

  logic                         hready;
  logic [N_PORTS-1:0]           req;
  logic [N_PORTS-1:0]           lock;
  logic [N_PORTS*W_WEIGHT-1:0]  weight;
  logic [N_PORTS-1:0]           gnt;
  logic [W_IDX-1:0]             gnt_idx;
  logic                         dph_valid;
  logic [N_PORTS-1:0]           dph_gnt;
  logic [W_IDX-1:0]             dph_idx;

  modport master (
    output hready, req, lock, weight,
    input  gnt, gnt_idx, dph_valid, dph_gnt, dph_idx
  );

  modport slave (
    input  hready, req, lock, weight,
    output gnt, gnt_idx, dph_valid, dph_gnt, dph_idx
  );

endinterface

// File: rtl/onehot_rr_pick.sv
// Combinational round-robin search: first set bit of req_i at or after
// start_i, wrapping past the top. Shared by several crossbar arbiters.
module onehot_rr_pick #(
  parameter int N_PORTS = 4,
  parameter int W_IDX   = 2
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [W_IDX-1:0]   start_i,
  output logic               found_o,
  output logic [W_IDX-1:0]   idx_o
);

  int unsigned pos;

  // NOTE: every output gets a default before the loop, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    found_o = 1'b0;
    idx_o   = start_i;
    pos     = 0;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      pos = (int'(start_i) + k) % N_PORTS;
      if (req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = W_IDX'(pos);
      end
    end
  end

endmodule

// File: rtl/ahbl_wrr_grant.sv
// Weighted round-robin address-phase grant for one AHB-Lite slave port, with
// HMASTLOCK honouring and data-phase owner tracking. Carries no bus payload.
module ahbl_wrr_grant
  import ahbl_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int W_WEIGHT = 4,
  parameter int W_IDX    = clog2(N_PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  ahbl_wrr_grant_if.slave  bus
);

  logic [W_IDX-1:0]    gnt_idx_q, gnt_idx_d;
  logic [W_IDX-1:0]    dph_idx_q, dph_idx_d;
  logic [W_WEIGHT-1:0] credit_q, credit_d;
  logic                dph_valid_q, dph_valid_d;

  logic                accept;
  logic                owner_locked;
  logic [W_IDX-1:0]    start_idx;
  logic                pick_found;
  logic [W_IDX-1:0]    pick_idx;
  logic [W_WEIGHT-1:0] pick_weight;
  logic [N_PORTS-1:0]  gnt_vec;
  logic [N_PORTS-1:0]  dph_gnt_vec;
  logic [W_WEIGHT-1:0] weight_arr [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_weight
    assign weight_arr[i] = bus.weight[W_WEIGHT*i +: W_WEIGHT];
  end

  assign accept       = bus.hready & bus.req[gnt_idx_q];
  assign owner_locked = bus.req[gnt_idx_q] & bus.lock[gnt_idx_q];

  // Search begins just past the owner, so the owner is considered last.
  assign start_idx = (gnt_idx_q == W_IDX'(N_PORTS - 1)) ? '0
                                                        : gnt_idx_q + W_IDX'(1);

  onehot_rr_pick #(
    .N_PORTS (N_PORTS),
    .W_IDX   (W_IDX)
  ) u_pick (
    .req_i   (bus.req),
    .start_i (start_idx),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign pick_weight = weight_arr[pick_idx];

  always_comb begin
    gnt_idx_d   = gnt_idx_q;
    credit_d    = credit_q;
    dph_idx_d   = dph_idx_q;
    dph_valid_d = dph_valid_q;
    if (bus.hready) begin
      dph_valid_d = accept;
      dph_idx_d   = gnt_idx_q;
      if (owner_locked) begin
        credit_d = credit_q;
      end else if (accept && (credit_q > W_WEIGHT'(1))) begin
        credit_d = credit_q - W_WEIGHT'(1);
      end else if (pick_found) begin
        gnt_idx_d = pick_idx;
        credit_d  = (pick_weight == '0) ? W_WEIGHT'(1) : pick_weight;
      end else begin
        // Park on the current owner with no turn open.
        credit_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx_q   <= '0;
      credit_q    <= '0;
      dph_idx_q   <= '0;
      dph_valid_q <= 1'b0;
    end else begin
      gnt_idx_q   <= gnt_idx_d;
      credit_q    <= credit_d;
      dph_idx_q   <= dph_idx_d;
      dph_valid_q <= dph_valid_d;
    end
  end

  // Outputs are pure decodes of registers: no input-to-output path.
  always_comb begin
    gnt_vec              = '0;
    gnt_vec[gnt_idx_q]   = 1'b1;
    dph_gnt_vec          = '0;
    dph_gnt_vec[dph_idx_q] = dph_valid_q;
  end

  assign bus.gnt       = gnt_vec;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.dph_valid = dph_valid_q;
  assign bus.dph_gnt   = dph_gnt_vec;
  assign bus.dph_idx   = dph_idx_q;

endmodule

// File: tb/tb_ahbl_wrr_grant.sv
// Directed bench for ahbl_wrr_grant (N=4, W_WEIGHT=4): hand-derived expected
// grant state is queued with each stimulus cycle and checked after the edge.
module tb_ahbl_wrr_grant;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic [3:0] credit;
    logic       dph_valid;
    logic [3:0] dph_gnt;
    logic [1:0] dph_idx;
  } snap_t;

  localparam logic [15:0] W_3111 = 16'h3111;
  localparam logic [15:0] W_1111 = 16'h1111;
  localparam logic [15:0] W_1113 = 16'h1113;
  localparam logic [15:0] W_1101 = 16'h1101;

  logic  clk;
  logic  rst;
  int    checks;
  int    errors;
  snap_t exp_q [$];

  ahbl_wrr_grant_if #(.N_PORTS(4), .W_WEIGHT(4)) bus ();

  ahbl_wrr_grant #(
    .N_PORTS  (4),
    .W_WEIGHT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [1:0] idx, input logic [3:0] cr,
                               input logic dv, input logic [1:0] dph);
    snap_t s;
    s.gnt       = 4'b0001 << idx;
    s.gnt_idx   = idx;
    s.credit    = cr;
    s.dph_valid = dv;
    s.dph_gnt   = dv ? (4'b0001 << dph) : 4'b0000;
    s.dph_idx   = dph;
    return s;
  endfunction

  task automatic check(input string tag);
    snap_t exp_s;
    snap_t obs;
    exp_s         = exp_q.pop_front();
    obs.gnt       = bus.gnt;
    obs.gnt_idx   = bus.gnt_idx;
    obs.credit    = dut.credit_q;
    obs.dph_valid = bus.dph_valid;
    obs.dph_gnt   = bus.dph_gnt;
    obs.dph_idx   = bus.dph_idx;
    checks++;
    assert (obs === exp_s) else begin
      errors++;
      $error("FAIL %s observed gnt=%b idx=%0d credit=%0d dv=%b dph_gnt=%b dph_idx=%0d expected gnt=%b idx=%0d credit=%0d dv=%b dph_gnt=%b dph_idx=%0d",
             tag, obs.gnt, obs.gnt_idx, obs.credit, obs.dph_valid, obs.dph_gnt, obs.dph_idx,
             exp_s.gnt, exp_s.gnt_idx, exp_s.credit, exp_s.dph_valid, exp_s.dph_gnt, exp_s.dph_idx);
    end
  endtask

  // Drive one cycle of inputs, queue the state expected after the edge, check.
  task automatic cyc(input logic r, input logic hr, input logic [3:0] rq,
                     input logic [3:0] lk, input logic [15:0] wt,
                     input logic [1:0] e_idx, input logic [3:0] e_cr,
                     input logic e_dv, input logic [1:0] e_dph, input string tag);
    rst        = r;
    bus.hready = hr;
    bus.req    = rq;
    bus.lock   = lk;
    bus.weight = wt;
    exp_q.push_back(mk(e_idx, e_cr, e_dv, e_dph));
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.hready = 1'b0;
    bus.req    = '0;
    bus.lock   = '0;
    bus.weight = W_1111;

    cyc(1, 1, 4'b0000, 4'b0000, W_1111, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 4'b0000, 4'b0000, W_1111, 0, 0, 0, 0, "idle_park");

    // Weights {3,1,1,1}: parked owner 0 accepted at once, then 1,2,3,3,3,0.
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 1, 1, 1, 0, "wrr_0");
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 2, 1, 1, 1, "wrr_1");
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 3, 3, 1, 2, "wrr_2");
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 3, 2, 1, 3, "wrr_3a");
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 3, 1, 1, 3, "wrr_3b");
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 0, 1, 1, 3, "wrr_3c");
    cyc(0, 1, 4'b1111, 4'b0000, W_3111, 1, 1, 1, 0, "wrr_0_again");

    // Locked master 2 against master 0; lock drops on a last-credit accept.
    cyc(0, 1, 4'b0101, 4'b0100, W_1111, 2, 1, 0, 1, "lock_grant");
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 4'b0101, 4'b0100, W_1111, 2, 1, 1, 2, "lock_hold");
    cyc(0, 1, 4'b0101, 4'b0000, W_1111, 0, 1, 1, 2, "lock_release");

    // Mid-turn wait states freeze everything while req/lock toggle.
    cyc(0, 1, 4'b0001, 4'b0000, W_1113, 0, 3, 1, 0, "regrant_w3");
    cyc(0, 1, 4'b0001, 4'b0000, W_1113, 0, 2, 1, 0, "credit_dec");
    cyc(0, 0, 4'b0000, 4'b1111, W_1113, 0, 2, 1, 0, "wait_freeze_a");
    cyc(0, 0, 4'b1110, 4'b1111, W_1113, 0, 2, 1, 0, "wait_freeze_b");
    cyc(0, 0, 4'b0101, 4'b0000, W_1113, 0, 2, 1, 0, "wait_freeze_c");
    cyc(0, 1, 4'b0011, 4'b0000, W_1113, 0, 1, 1, 0, "resume");
    cyc(0, 1, 4'b0011, 4'b0000, W_1113, 1, 1, 1, 0, "resume_move");

    // Weight 0 on master 1 behaves as 1; sole requester re-grants itself.
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 4'b0010, 4'b0000, W_1101, 1, 1, 1, 1, "w0_selfloop");
    cyc(0, 1, 4'b0000, 4'b0000, W_1101, 1, 0, 0, 1, "park");
    cyc(0, 1, 4'b0010, 4'b0000, W_1101, 1, 1, 1, 1, "park_issue");

    // Reset during a wait state inside a locked burst.
    cyc(0, 1, 4'b0010, 4'b0010, W_1101, 1, 1, 1, 1, "lockb_a");
    cyc(0, 1, 4'b0010, 4'b0010, W_1101, 1, 1, 1, 1, "lockb_b");
    cyc(1, 0, 4'b0010, 4'b0010, W_1101, 0, 0, 0, 0, "rst_mid_lock");
    cyc(0, 1, 4'b0000, 4'b0000, W_1101, 0, 0, 0, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
